// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
// Shared types for the vector register file read-side sequencer.
//   ELEM_W / RF_LEN / ADDR_W : default element width, file length, address width
//   elem_t / eaddr_t / elen_t : element value, element address, element count
//   stream_state_e            : sequencer FSM states
// -----------------------------------------------------------------------------
package vector_pkg;

   localparam int ELEM_W = 32;
   localparam int RF_LEN = 32;
   localparam int ADDR_W = 5;

   typedef logic [ELEM_W-1:0] elem_t;
   typedef logic [ADDR_W-1:0] eaddr_t;
   typedef logic [ADDR_W:0]   elen_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } stream_state_e;

endpackage

// File: rtl/vector_elem_stream_if.sv
// -----------------------------------------------------------------------------
// vector_elem_stream_if
// Bundles the command channel, the register file read port and the element
// output stream of vector_elem_stream.
//   slave  : sequencer view (takes commands and read data, drives rf_addr/out_*)
//   master : environment view (issues commands, serves reads, consumes elements)
// -----------------------------------------------------------------------------
interface vector_elem_stream_if
   import vector_pkg::*;
#(
   parameter int W = ELEM_W,
   parameter int A = ADDR_W
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [A-1:0] cmd_base;
   logic [A:0]   cmd_len;
   logic         cmd_err;
   logic         abort;
   logic [A-1:0] rf_addr;
   logic         rf_write;
   logic [W-1:0] rf_rdata;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [A-1:0] out_idx;
   logic         out_last;
   logic         busy;

   modport slave (
      input  cmd_valid, cmd_base, cmd_len, abort, rf_rdata, out_ready,
      output cmd_ready, cmd_err, rf_addr, rf_write, out_valid, out_data,
             out_idx, out_last, busy
   );

   modport master (
      output cmd_valid, cmd_base, cmd_len, abort, rf_rdata, out_ready,
      input  cmd_ready, cmd_err, rf_addr, rf_write, out_valid, out_data,
             out_idx, out_last, busy
   );
endinterface

// File: rtl/vector_skid_buf.sv
// -----------------------------------------------------------------------------
// vector_skid_buf
// Two-entry skid buffer with registered outputs. The head entry drives the
// output and only changes when empty or popped, so payload is stable while
// out_valid waits for out_ready. The writer must never push into a full buffer.
//   clk, n_reset : clock, synchronous active-low reset
//   flush        : drop both entries (payload registers keep their values)
//   in_valid/in_data   : push side
//   out_ready/out_valid/out_data : pop side
//   count        : entries currently held (0..2)
// -----------------------------------------------------------------------------
module vector_skid_buf #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [PW-1:0] in_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [PW-1:0] out_data,
   output logic [1:0]    count
);

   logic          tail_vld;
   logic [PW-1:0] tail_data;
   logic          pop;

   assign pop   = out_valid & out_ready;
   assign count = {1'b0, out_valid} + {1'b0, tail_vld};

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         out_valid <= 1'b0;
         tail_vld  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         tail_vld  <= 1'b0;
      end else if (pop) begin
         // tail (if any) moves to head; an incoming entry refills the gap
         if (tail_vld) tail_vld  <= in_valid;
         else          out_valid <= in_valid;
      end else if (in_valid) begin
         if (!out_valid) out_valid <= 1'b1;
         else            tail_vld  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         out_data <= '0;
      end else if (!flush) begin
         if (pop && tail_vld)
            out_data <= tail_data;
         else if (in_valid && (pop || !out_valid))
            out_data <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid && ((pop && tail_vld) || (!pop && out_valid && !tail_vld)))
         tail_data <= in_data;
   end

endmodule

// File: rtl/vector_elem_stream.sv
// -----------------------------------------------------------------------------
// vector_elem_stream
// Read-side sequencer behind the vector register file. Takes one command
// (base address, element count), walks the read port one element per cycle
// and streams {data, idx, last} to the execute stage with back-pressure.
//   clk, n_reset : clock, synchronous active-low reset
//   bus (slave)  : cmd_* command channel, abort, rf_* read port (read-only),
//                  out_* element stream, busy
// -----------------------------------------------------------------------------
module vector_elem_stream
   import vector_pkg::*;
#(
   parameter int W = ELEM_W,
   parameter int L = RF_LEN,
   parameter int A = ADDR_W
) (
   input  logic                 clk,
   input  logic                 n_reset,
   vector_elem_stream_if.slave  bus
);

   localparam int          PW      = W + A + 1;
   localparam logic [A:0]  LEN_MAX = (A+1)'(L);

   stream_state_e  state;
   logic           cmd_ready;
   logic           cmd_err;
   logic           busy;
   logic [A-1:0]   rf_addr;
   logic [A:0]     len_q;
   logic [A:0]     cnt;

   logic           vld_p1;
   logic [PW-1:0]  pay_p1;

   logic           buf_valid;
   logic [PW-1:0]  buf_data;
   logic [1:0]     buf_count;

   logic           pop;
   logic           issue;
   logic           last_issue;
   logic           cmd_fire;
   logic [1:0]     occ;
   logic [1:0]     held;

   function automatic logic len_legal(input logic [A:0] len);
      return (len != '0) && (len <= LEN_MAX);
   endfunction

   // Occupancy counts the read-data stage plus the skid entries, so a read
   // is only issued when its element is guaranteed a slot downstream.
   assign pop        = buf_valid & bus.out_ready;
   assign occ        = buf_count + {1'b0, vld_p1};
   assign held       = occ - {1'b0, pop};
   assign issue      = (state == STREAM) && !bus.abort && (held < 2'd2);
   assign last_issue = (cnt == len_q - (A+1)'(1));
   assign cmd_fire   = bus.cmd_valid && cmd_ready && !bus.abort;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         cmd_err   <= 1'b0;
         busy      <= 1'b0;
         rf_addr   <= '0;
         len_q     <= '0;
         cnt       <= '0;
      end else begin
         cmd_err <= 1'b0;
         if (bus.abort) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_fire) begin
                     if (len_legal(bus.cmd_len)) begin
                        len_q     <= bus.cmd_len;
                        cnt       <= '0;
                        rf_addr   <= bus.cmd_base;
                        state     <= STREAM;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                     end else begin
                        cmd_err <= 1'b1;
                     end
                  end
               end
               STREAM: begin
                  if (issue) begin
                     cnt     <= cnt + (A+1)'(1);
                     // wraps modulo L by truncation to A bits
                     rf_addr <= rf_addr + A'(1);
                     if (last_issue) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (pop && buf_data[0]) begin
                     state     <= IDLE;
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
               default: begin
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

   // ---- stage p1: capture register file read data ----
   always_ff @(posedge clk) begin
      if (!n_reset) vld_p1 <= 1'b0;
      else          vld_p1 <= issue;
   end

   always_ff @(posedge clk) begin
      if (issue) pay_p1 <= {bus.rf_rdata, cnt[A-1:0], last_issue};
   end

   // ---- stage p2: skid buffer drives the output stream ----
   vector_skid_buf #(.PW(PW)) u_skid (
      .clk       (clk),
      .n_reset   (n_reset),
      .flush     (bus.abort),
      .in_valid  (vld_p1),
      .in_data   (pay_p1),
      .out_ready (bus.out_ready),
      .out_valid (buf_valid),
      .out_data  (buf_data),
      .count     (buf_count)
   );

   assign bus.cmd_ready = cmd_ready;
   assign bus.cmd_err   = cmd_err;
   assign bus.busy      = busy;
   assign bus.rf_addr   = rf_addr;
   assign bus.rf_write  = 1'b0;
   assign bus.out_valid = buf_valid;
   assign bus.out_data  = buf_data[PW-1:A+1];
   assign bus.out_idx   = buf_data[A:1];
   assign bus.out_last  = buf_data[0];

endmodule

// File: tb/tb_vector_elem_stream.sv
// -----------------------------------------------------------------------------
// tb_vector_elem_stream
// Scoreboard bench for vector_elem_stream: expected elements are queued when a
// command is accepted and compared as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_vector_elem_stream;
   import vector_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  idx;
      logic        last;
   } exp_t;

   logic        clk;
   logic        n_reset;
   logic [31:0] mem [32];
   exp_t        q[$];
   int          checks;
   int          errors;
   int          delivered;
   int          rdy_mode;
   logic        aborting;
   logic        track_en;
   logic [4:0]  track_base;

   vector_elem_stream_if #(.W(32), .A(5)) bus ();

   vector_elem_stream #(.W(32), .L(32), .A(5)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   assign bus.rf_rdata = mem[bus.rf_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      check({tag, "_cmd_err"},   bus.cmd_err,   0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_data"},  bus.out_data,  0);
      check({tag, "_out_idx"},   bus.out_idx,   0);
      check({tag, "_out_last"},  bus.out_last,  0);
      check({tag, "_busy"},      bus.busy,      0);
      check({tag, "_rf_addr"},   bus.rf_addr,   0);
      check({tag, "_rf_write"},  bus.rf_write,  0);
   endtask

   // Offer a command at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic send_cmd(input logic [4:0] base, input logic [5:0] len);
      bit done;
      done = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_base  = base;
      bus.cmd_len   = len;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            if (len >= 1 && len <= 32) begin
               for (int e = 0; e < int'(len); e++) begin
                  exp_t x;
                  x.data = mem[(int'(base) + e) % 32];
                  x.idx  = 5'(e);
                  x.last = (e == int'(len) - 1);
                  q.push_back(x);
               end
            end
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      if (!done) check("cmd_accept_timeout", 0, 1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!bus.busy && q.size() == 0) break;
      end
      check({tag, "_busy"},    bus.busy, 0);
      check({tag, "_drained"}, q.size(), 0);
   endtask

   // out_ready driver: always ready, or a 1,0,0 repeating pattern
   initial begin
      int k;
      k = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) begin
            bus.out_ready = 1'b1;
         end else begin
            bus.out_ready = (k % 3 == 0);
            k++;
         end
      end
   end

   // Output monitor: scoreboard compare, hold-while-stalled, in-flight bound
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      logic [4:0]  prev_idx;
      logic        prev_last;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_idx   = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!n_reset || aborting) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", bus.out_valid, 1);
               check("hold_data",  bus.out_data,  prev_data);
               check("hold_idx",   bus.out_idx,   prev_idx);
               check("hold_last",  bus.out_last,  prev_last);
            end
            if (track_en && bus.busy)
               check("inflight_le2", (5'(bus.rf_addr - track_base) - delivered) <= 2, 1);
            if (bus.out_valid && q.size() == 0)
               check("spurious_valid", bus.out_valid, 0);
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
               exp_t x;
               x = q.pop_front();
               check("out_data", bus.out_data, x.data);
               check("out_idx",  bus.out_idx,  x.idx);
               check("out_last", bus.out_last, x.last);
               delivered++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_idx   = bus.out_idx;
            prev_last  = bus.out_last;
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      delivered = 0;
      rdy_mode  = 0;
      aborting  = 1'b0;
      track_en  = 1'b0;
      track_base = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'(i * 3);
      n_reset       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      bus.abort     = 1'b0;
      repeat (2) @(posedge clk);
      #1 n_reset = 1'b1;
      @(negedge clk);
      check_reset_vals("por");

      // element stream with exact first-element latency
      @(posedge clk); #1;
      send_cmd(5'd4, 6'd3);
      @(negedge clk); check("lat_n0_valid", bus.out_valid, 0);
      @(negedge clk); check("lat_n1_valid", bus.out_valid, 0);
      @(negedge clk); check("lat_n2_valid", bus.out_valid, 1);
      check("lat_first_data", bus.out_data, 12);
      wait_idle("basic");

      // address wrap-around
      @(posedge clk); #1;
      send_cmd(5'd30, 6'd4);
      @(negedge clk); check("wrap_addr0", bus.rf_addr, 30);
      @(negedge clk); check("wrap_addr1", bus.rf_addr, 31);
      @(negedge clk); check("wrap_addr2", bus.rf_addr, 0);
      @(negedge clk); check("wrap_addr3", bus.rf_addr, 1);
      wait_idle("wrap");

      // back-pressure
      @(posedge clk); #1;
      rdy_mode   = 1;
      delivered  = 0;
      track_base = 5'd8;
      track_en   = 1'b1;
      send_cmd(5'd8, 6'd8);
      wait_idle("bp");
      check("bp_count", delivered, 8);
      track_en = 1'b0;
      rdy_mode = 0;

      // illegal lengths
      for (int t = 0; t < 2; t++) begin
         @(posedge clk); #1;
         send_cmd(5'd3, (t == 0) ? 6'd0 : 6'd33);
         @(negedge clk);
         check("err_pulse",    bus.cmd_err,   1);
         check("err_busy",     bus.busy,      0);
         check("err_no_valid", bus.out_valid, 0);
         @(negedge clk);
         check("err_clear",    bus.cmd_err,   0);
         check("err_busy2",    bus.busy,      0);
      end

      // reset mid-stream
      @(posedge clk); #1;
      send_cmd(5'd0, 6'd10);
      repeat (3) @(posedge clk);
      #1 n_reset = 1'b0;
      @(posedge clk);
      #1 n_reset = 1'b1;
      q.delete();
      @(negedge clk);
      check_reset_vals("midrst");

      // abort after two elements, then a single-element command
      @(posedge clk); #1;
      delivered = 0;
      send_cmd(5'd0, 6'd10);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (delivered >= 2) break;
      end
      check("abort_reached2", delivered >= 2, 1);
      #1;
      bus.abort = 1'b1;
      aborting  = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      q.delete();
      aborting  = 1'b0;
      @(negedge clk);
      check("abort_valid",     bus.out_valid, 0);
      check("abort_busy",      bus.busy,      0);
      check("abort_cmd_ready", bus.cmd_ready, 1);
      @(posedge clk); #1;
      send_cmd(5'd5, 6'd1);
      wait_idle("post_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
